// File: rtl/pe_comp_sched_pkg.sv
// Shared types and encodings for the per-PE computation scheduler.
package pe_comp_sched_pkg;

    localparam int COMP_EN_W = 1;
    localparam logic [COMP_EN_W-1:0] COMP_EN_IDLE = 1'b0;
    localparam logic [COMP_EN_W-1:0] COMP_EN_COMP = 1'b1;

    localparam int PE_DATA_W   = 16;
    localparam int PE_ACT_NO_W = 6;

    typedef logic [COMP_EN_W-1:0]   comp_en_bus_t;
    typedef logic [PE_DATA_W-1:0]   pe_data_bus_t;
    typedef logic [PE_ACT_NO_W-1:0] pe_act_no_bus_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DRAIN = 2'd3
    } sched_state_t;

    // Drain counter must hold 0..cyc inclusive; never narrower than one bit.
    function automatic int drain_cnt_w(input int cyc);
        return (cyc < 1) ? 1 : $clog2(cyc + 1);
    endfunction

endpackage

// File: rtl/pe_comp_sched.sv
// Per-PE computation scheduler: walks the output range per nonzero input
// activation, reads weights and feeds the multiply stage.
//
// state | meaning
// IDLE  | waiting for start, queue not consumed
// FETCH | ready for the next activation (bubble after empty queue)
// ISSUE | one weight read per cycle for the held activation
// DRAIN | let mult/add/write-back finish, then pulse done
module pe_comp_sched
    import pe_comp_sched_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ACT_NO_W  = 6,
    parameter int IN_IDX_W  = 8,
    parameter int DRAIN_CYC = 3,
    parameter int SKIP_ZERO = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ACT_NO_W-1:0]          cfg_num_out,
    input  logic                         in_act_valid,
    output logic                         in_act_ready,
    input  logic [IN_IDX_W-1:0]          in_act_idx,
    input  logic [DATA_W-1:0]            in_act_value,
    input  logic                         in_act_last,
    output logic                         mem_rd_en,
    output logic [IN_IDX_W+ACT_NO_W-1:0] mem_rd_addr,
    output logic [COMP_EN_W-1:0]         comp_en_mult,
    output logic [DATA_W-1:0]            in_act_value_mult,
    output logic [ACT_NO_W-1:0]          out_act_addr_mult,
    output logic                         busy,
    output logic                         done
);

    localparam int DRN_W = drain_cnt_w(DRAIN_CYC);

    sched_state_t        state_q, state_d;
    logic [ACT_NO_W-1:0] num_r, out_idx, out_idx_d;
    logic [IN_IDX_W-1:0] idx_r;
    logic [DATA_W-1:0]   value_r;
    logic                last_r;
    logic [DRN_W-1:0]    drain_cnt, drain_cnt_d;
    logic                hs, drop, final_issue, drain_tc, latch_act;

    assign hs          = in_act_valid & in_act_ready;
    assign drop        = ((SKIP_ZERO != 0) && (in_act_value == '0)) || (num_r == '0);
    assign final_issue = (out_idx == num_r - 1'b1);
    assign drain_tc    = (drain_cnt == DRN_W'(DRAIN_CYC));

    assign mem_rd_en   = (state_q == ST_ISSUE);
    assign mem_rd_addr = {idx_r, out_idx};
    assign busy        = (state_q != ST_IDLE);

    always_comb begin
        state_d      = state_q;
        out_idx_d    = out_idx;
        drain_cnt_d  = drain_cnt;
        in_act_ready = 1'b0;
        latch_act    = 1'b0;
        done         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                in_act_ready = 1'b1;
                if (hs) begin
                    latch_act = 1'b1;
                    if (drop) begin
                        state_d = in_act_last ? ST_DRAIN : ST_FETCH;
                    end else begin
                        out_idx_d = '0;
                        state_d   = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (!final_issue) begin
                    out_idx_d = out_idx + 1'b1;
                end else if (last_r) begin
                    state_d = ST_DRAIN;
                end else begin
                    // Overlap the next fetch with the final issue to avoid a bubble.
                    in_act_ready = 1'b1;
                    if (hs) begin
                        latch_act = 1'b1;
                        if (drop) begin
                            state_d = in_act_last ? ST_DRAIN : ST_FETCH;
                        end else begin
                            out_idx_d = '0;
                        end
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_tc) begin
                    done        = 1'b1;
                    drain_cnt_d = '0;
                    state_d     = ST_IDLE;
                end else begin
                    drain_cnt_d = drain_cnt + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            num_r     <= '0;
            out_idx   <= '0;
            idx_r     <= '0;
            value_r   <= '0;
            last_r    <= 1'b0;
            drain_cnt <= '0;
        end else begin
            state_q   <= state_d;
            out_idx   <= out_idx_d;
            drain_cnt <= drain_cnt_d;
            if (state_q == ST_IDLE && start) num_r <= cfg_num_out;
            if (latch_act) begin
                idx_r   <= in_act_idx;
                value_r <= in_act_value;
                last_r  <= in_act_last;
            end
        end
    end

    // Mult stage lags the issue by the one-cycle weight read; data holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            comp_en_mult      <= COMP_EN_IDLE;
            in_act_value_mult <= '0;
            out_act_addr_mult <= '0;
        end else begin
            comp_en_mult <= mem_rd_en ? COMP_EN_COMP : COMP_EN_IDLE;
            if (mem_rd_en) begin
                in_act_value_mult <= value_r;
                out_act_addr_mult <= out_idx;
            end
        end
    end

endmodule

// File: tb/tb_pe_comp_sched.sv
// Scoreboard bench for pe_comp_sched: expected reads/products queued per pass,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_pe_comp_sched;
    import pe_comp_sched_pkg::*;

    localparam int DATA_W    = 16;
    localparam int ACT_NO_W  = 6;
    localparam int IN_IDX_W  = 8;
    localparam int DRAIN_CYC = 3;
    localparam int SKIP_ZERO = 1;

    logic                         clk, rst, start;
    logic [ACT_NO_W-1:0]          cfg_num_out;
    logic                         in_act_valid, in_act_ready, in_act_last;
    logic [IN_IDX_W-1:0]          in_act_idx;
    logic [DATA_W-1:0]            in_act_value;
    logic                         mem_rd_en;
    logic [IN_IDX_W+ACT_NO_W-1:0] mem_rd_addr;
    logic [COMP_EN_W-1:0]         comp_en_mult;
    logic [DATA_W-1:0]            in_act_value_mult;
    logic [ACT_NO_W-1:0]          out_act_addr_mult;
    logic                         busy, done;

    pe_comp_sched #(
        .DATA_W(DATA_W), .ACT_NO_W(ACT_NO_W), .IN_IDX_W(IN_IDX_W),
        .DRAIN_CYC(DRAIN_CYC), .SKIP_ZERO(SKIP_ZERO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_num_out(cfg_num_out),
        .in_act_valid(in_act_valid), .in_act_ready(in_act_ready),
        .in_act_idx(in_act_idx), .in_act_value(in_act_value), .in_act_last(in_act_last),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .comp_en_mult(comp_en_mult),
        .in_act_value_mult(in_act_value_mult), .out_act_addr_mult(out_act_addr_mult),
        .busy(busy), .done(done)
    );

    typedef struct packed {
        logic [IN_IDX_W-1:0] idx;
        logic [DATA_W-1:0]   val;
    } act_t;

    typedef struct packed {
        logic [IN_IDX_W+ACT_NO_W-1:0] addr;
        logic [DATA_W-1:0]            val;
        logic [ACT_NO_W-1:0]          oaddr;
    } prod_t;

    prod_t exp_rd_q[$];
    prod_t exp_prod_q[$];
    act_t  pass_acts[$];
    prod_t mon_p;

    int checks = 0, errors = 0, cyc = 0;
    int first_iss = 0, last_iss = 0, end_cyc = 0, n_iss = 0, done_cnt = 0;
    bit mon_en = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares every read, every product and every done pulse.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (mem_rd_en) begin
                if (exp_rd_q.size() == 0) chk("unexpected_rd", 1, 0);
                else begin
                    mon_p = exp_rd_q.pop_front();
                    chk("rd_addr", mem_rd_addr, mon_p.addr);
                end
                if (n_iss == 0) first_iss = cyc;
                last_iss = cyc;
                n_iss++;
                if (cyc > end_cyc) end_cyc = cyc;
            end
            if (in_act_valid && in_act_ready && in_act_last && cyc > end_cyc) end_cyc = cyc;
            if (comp_en_mult == COMP_EN_COMP) begin
                if (exp_prod_q.size() == 0) chk("unexpected_prod", 1, 0);
                else begin
                    mon_p = exp_prod_q.pop_front();
                    chk("prod_value", in_act_value_mult, mon_p.val);
                    chk("prod_oaddr", out_act_addr_mult, mon_p.oaddr);
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_latency", cyc - end_cyc, DRAIN_CYC + 1);
                chk("done_rd_pending", exp_rd_q.size(), 0);
                chk("done_prod_pending", exp_prod_q.size(), 0);
            end
        end
    end

    function automatic act_t mk(input int idx, input int val);
        act_t a;
        a.idx = IN_IDX_W'(idx);
        a.val = DATA_W'(val);
        return a;
    endfunction

    task automatic do_start(input int num);
        start = 1'b1;
        cfg_num_out = ACT_NO_W'(num);
        @(posedge clk); #1;
        start = 1'b0;
        cfg_num_out = ACT_NO_W'($urandom);
    endtask

    task automatic send_act(input act_t a, input bit last);
        bit ok = 1'b0;
        in_act_valid = 1'b1;
        in_act_idx   = a.idx;
        in_act_value = a.val;
        in_act_last  = last;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (in_act_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("act_accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_act_valid = 1'b0;
        in_act_idx   = IN_IDX_W'($urandom);
        in_act_value = DATA_W'($urandom);
        in_act_last  = 1'b0;
    endtask

    // Reference model: each kept activation yields num reads at {idx, j}, j = 0..num-1.
    task automatic run_pass(input int num, input bit gaps, input bit start_mid);
        prod_t p;
        int    d0;
        bit    nobubble;
        nobubble = !gaps && (num > 0);
        foreach (pass_acts[i]) begin
            if (pass_acts[i].val == '0 && SKIP_ZERO != 0) nobubble = 1'b0;
            else if (num > 0) begin
                for (int j = 0; j < num; j++) begin
                    p.addr  = {pass_acts[i].idx, ACT_NO_W'(j)};
                    p.val   = pass_acts[i].val;
                    p.oaddr = ACT_NO_W'(j);
                    exp_rd_q.push_back(p);
                    exp_prod_q.push_back(p);
                end
            end
        end
        n_iss = 0;
        end_cyc = 0;
        d0 = done_cnt;
        do_start(num);
        foreach (pass_acts[i]) begin
            if (gaps && $urandom_range(0, 2) == 0)
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            if (start_mid && i == 1) begin
                start = 1'b1;
                cfg_num_out = ACT_NO_W'(num + 5);
                @(posedge clk); #1;
                start = 1'b0;
                chk("busy_after_mid_start", busy, 1);
            end
            send_act(pass_acts[i], i == pass_acts.size() - 1);
        end
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done_cnt != d0) break;
        end
        chk("done_seen", done_cnt - d0, 1);
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("rd_all_issued", exp_rd_q.size(), 0);
        if (nobubble && n_iss > 0) chk("no_bubble_span", last_iss - first_iss, n_iss - 1);
        exp_rd_q.delete();
        exp_prod_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        bit seen;
        int d0;
        rst = 1'b1; start = 1'b0; cfg_num_out = '0;
        in_act_valid = 1'b0; in_act_idx = '0; in_act_value = '0; in_act_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_comp_en", comp_en_mult, COMP_EN_IDLE);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_ready", in_act_ready, 0);
        chk("rst_value_mult", in_act_value_mult, 0);
        rst = 1'b0;
        // Entries offered while idle must not be taken.
        in_act_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_ready", in_act_ready, 0);
        end
        in_act_valid = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;

        pass_acts = {};
        pass_acts.push_back(mk(3, 5));
        run_pass(4, 0, 0);

        pass_acts = {};
        pass_acts.push_back(mk(1, 7));
        pass_acts.push_back(mk(2, -3));
        run_pass(2, 0, 0);

        pass_acts = {};
        pass_acts.push_back(mk(0, 0));
        pass_acts.push_back(mk(5, 0));
        pass_acts.push_back(mk(6, 2));
        run_pass(3, 0, 0);

        pass_acts = {};
        pass_acts.push_back(mk(4, 9));
        pass_acts.push_back(mk(8, 1));
        pass_acts.push_back(mk(9, 2));
        run_pass(0, 0, 0);

        pass_acts = {};
        pass_acts.push_back(mk(10, 11));
        pass_acts.push_back(mk(11, 12));
        pass_acts.push_back(mk(12, 13));
        pass_acts.push_back(mk(13, 14));
        run_pass(3, 1, 1);

        pass_acts = {};
        pass_acts.push_back(mk(200, 16'h8001));
        pass_acts.push_back(mk(255, 16'h7fff));
        run_pass(63, 0, 0);

        for (int r = 0; r < 8; r++) begin
            int n;
            pass_acts = {};
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++)
                pass_acts.push_back(mk($urandom_range(0, 255),
                                       ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 65535)));
            run_pass($urandom_range(0, 7), r[0], 0);
        end

        // Abort in the middle of ISSUE.
        mon_en = 1'b0;
        do_start(8);
        in_act_valid = 1'b1; in_act_idx = 8'd7; in_act_value = 16'd3; in_act_last = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (mem_rd_en) begin seen = 1'b1; break; end
        end
        chk("reach_issue", seen, 1);
        @(posedge clk); #1;
        in_act_valid = 1'b0; in_act_last = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_comp_en", comp_en_mult, COMP_EN_IDLE);
        chk("abort_busy", busy, 0);
        chk("abort_ready", in_act_ready, 0);
        chk("abort_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        d0 = done_cnt;
        mon_en = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - d0, 0);

        pass_acts = {};
        pass_acts.push_back(mk(21, 100));
        pass_acts.push_back(mk(22, 0));
        pass_acts.push_back(mk(23, 200));
        run_pass(5, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
